alu_mc: RTL and testbench



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_muldiv_iter.sv | 81 ++++++++
 rtl/alu_mc.sv | 117 +++++++++++
 tb/tb_alu_mc.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and shared helpers for the multi-cycle ALU.
// Imported by alu_mc and alu_muldiv_iter.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_mode_t;

  // x / 0 gives all-ones; x % 0 gives the dividend back
  localparam logic DIVZ_QUOT_FILL = 1'b1;
  localparam logic DIVZ_REM_OP1   = 1'b1;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic md_mode_t op_mode(input logic [3:0] op);
    md_mode_t m;
    m = MD_MUL;
    if (op == OP_DIVU) m = MD_DIVU;
    else if (op == OP_REMU) m = MD_REMU;
    return m;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: WIDTH-step shift-add multiply / restoring divide.
// done and res are combinational on the final step so the caller can latch them.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_mode_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             busy;
  md_mode_t         mode_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] sr_n;
  logic [WIDTH-1:0] dvs_n;

  // one iteration: add shifted multiplicand, or trial-subtract the divisor
  always_comb begin
    rem_sh = {acc, sr[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    acc_n  = acc;
    sr_n   = sr;
    dvs_n  = dvs;
    if (mode_q == MD_MUL) begin
      acc_n = acc + (sr[0] ? dvs : '0);
      sr_n  = sr >> 1;
      dvs_n = dvs << 1;
    end else if (!diff[WIDTH]) begin
      acc_n = diff[WIDTH-1:0];
      sr_n  = {sr[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = rem_sh[WIDTH-1:0];
      sr_n  = {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));
  assign res  = (mode_q == MD_DIVU) ? sr_n : acc_n;

  // load on start, then step once per cycle until the count runs out
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      sr     <= '0;
      dvs    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      mode_q <= MD_MUL;
    end else if (start) begin
      acc    <= '0;
      sr     <= (mode == MD_MUL) ? b : a;
      dvs    <= (mode == MD_MUL) ? a : b;
      cnt    <= '0;
      busy   <= 1'b1;
      mode_q <= mode;
    end else if (busy) begin
      acc <= acc_n;
      sr  <= sr_n;
      dvs <= dvs_n;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU with valid/ready on both sides and a
// registered result; MUL/DIVU/REMU run iteratively for WIDTH cycles.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_t           state;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] op1_q;
  logic [3:0]       op_q;
  logic             div0_q;
  logic             iter_done;
  logic             accept;
  logic [SHW-1:0]   sh;

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign sh        = op2[SHW-1:0];

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .start(accept && is_iter(alu_op)),
    .mode (op_mode(alu_op)),
    .a    (op1),
    .b    (op2),
    .done (iter_done),
    .res  (iter_res)
  );

  // single-cycle ALU on the live operands; only latched on the accept edge
  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SRL:  alu_res = op1 >> sh;
      OP_SLL:  alu_res = op1 << sh;
      OP_SRA:  alu_res = WIDTH'($signed(op1) >>> sh);
      default: alu_res = '0;
    endcase
  end

  // apply the divide-by-zero convention on top of the iterator result
  always_comb begin
    fin_res = iter_res;
    if (div0_q && op_q == OP_DIVU)
      fin_res = {WIDTH{DIVZ_QUOT_FILL}};
    else if (div0_q && op_q == OP_REMU && DIVZ_REM_OP1)
      fin_res = op1_q;
  end

  // IDLE -> (CALC) -> DONE -> IDLE, result and zero registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      result <= '0;
      zero   <= 1'b0;
      op1_q  <= '0;
      op_q   <= '0;
      div0_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op1_q  <= op1;
            op_q   <= alu_op;
            div0_q <= (op2 == '0);
            if (is_iter(alu_op)) begin
              state <= ST_CALC;
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              state  <= ST_DONE;
            end
          end
        end
        ST_CALC: begin
          if (iter_done) begin
            result <= fin_res;
            zero   <= (fin_res == '0);
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random ops against a transaction-level
// reference model, checked on every falling edge.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [3:0]  alu_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0101: return a ^ b;
      4'b1000: return a >> b[4:0];
      4'b1001: return a << b[4:0];
      4'b1010: return 32'($signed(a) >>> b[4:0]);
      4'b1100: begin
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
      end
      4'b1101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1110: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // transaction model: one op in flight, fixed latency per op class
  logic        m_pend = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_exp = '0;
  logic        m_zero = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_res   = '0;
      m_zero  = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_pend  = 1'b0;
        m_valid = 1'b1;
        m_res   = m_exp;
        m_zero  = (m_exp == 0);
      end
    end else if (in_valid) begin
      m_exp = ref_alu(alu_op, op1, op2);
      if (alu_op inside {4'b1100, 4'b1101, 4'b1110}) begin
        m_pend = 1'b1;
        m_cnt  = 32;
      end else begin
        m_valid = 1'b1;
        m_res   = m_exp;
        m_zero  = (m_exp == 0);
      end
    end
  end

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    chk("in_ready", in_ready, !rst && !m_pend && !m_valid);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("result", result, m_res);
      chk("zero", zero, m_zero);
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    logic r;
    logic ok;
    ok = 1'b0;
    alu_op = op;
    op1 = a;
    op2 = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    alu_op = 4'($urandom);
    op1 = $urandom;
    op2 = $urandom;
    chk("accept", ok, 1'b1);
  endtask

  // returns at a falling edge with out_valid high; lat counts edges since E
  task automatic wait_valid(output int lat);
    logic seen;
    seen = 1'b0;
    lat = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    chk("wait_valid", seen, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic exp_z,
                        input int exp_lat);
    int lat;
    send(op, a, b);
    wait_valid(lat);
    chk(name, result, exp);
    chk({name, "_zero"}, zero, exp_z);
    chk({name, "_lat"}, lat, exp_lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic v;
    logic done;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    chk("pin_mul", ref_alu(4'b1100, 32'h0001_0000, 32'h0001_0001),
        32'h0001_0000);
    chk("pin_divu", ref_alu(4'b1101, 32'd100, 32'd7), 32'd14);
    chk("pin_remu0", ref_alu(4'b1110, 32'd5, 32'd0), 32'd5);
    chk("pin_sra", ref_alu(4'b1010, 32'h8000_0000, 32'h24), 32'hF800_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1);
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1);
    run_op("slt", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1);
    run_op("sra", 4'b1010, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1);
    run_op("unk", 4'b1111, 32'h1234, 32'h5678, 32'd0, 1, 1);
    run_op("sub", 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1);
    run_op("sll", 4'b1001, 32'h1, 32'h3F, 32'h8000_0000, 0, 1);
    run_op("mul", 4'b1100, 32'h0001_0000, 32'h0001_0001,
           32'h0001_0000, 0, 33);
    run_op("divu", 4'b1101, 32'd100, 32'd7, 32'd14, 0, 33);
    run_op("remu", 4'b1110, 32'd100, 32'd7, 32'd2, 0, 33);
    run_op("divu0", 4'b1101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 33);
    run_op("remu0", 4'b1110, 32'd5, 32'd0, 32'd5, 0, 33);

    out_ready = 1'b0;
    send(4'b1101, 32'd1000, 32'd7);
    wait_valid(lat);
    chk("bp_lat", lat, 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      alu_op = 4'b0010;
      op1 = $urandom;
      @(negedge clk);
      chk("bp_result", result, 32'd142);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    chk("bp_release_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    send(4'b1100, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", zero, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 0, 1);

    for (int n = 0; n < 80; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      out_ready = 1'($urandom_range(0, 1));
      send(rop, ra, rb);
      done = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        v = out_valid;
        @(posedge clk);
        if (v && out_ready) begin
          done = 1'b1;
          break;
        end
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
      #1;
      out_ready = 1'b1;
      chk("rand_done", done, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
